// File: rtl/pwm_capture_pkg.sv
// Shared PWM definitions used by both the generator and the capture block.
package pwm_capture_pkg;
   localparam int PWM_RESOLUTION = 8;
endpackage

// File: rtl/pwm_capture_if.sv
// Measurement results bundle: capture block drives it, consumers read it.
interface pwm_capture_if
   import pwm_capture_pkg::*;
#(
   parameter int RESOLUTION = PWM_RESOLUTION
);
   logic [RESOLUTION-1:0] o_top;
   logic [RESOLUTION:0]   o_compare;
   logic                  o_valid;
   logic                  o_steady;

   modport master (
      output o_top,
      output o_compare,
      output o_valid,
      output o_steady
   );

   modport slave (
      input o_top,
      input o_compare,
      input o_valid,
      input o_steady
   );
endinterface

// File: rtl/pwm_capture_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   logic meta;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         meta <= 1'b0;
         o_q  <= 1'b0;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end
endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM waveform,
// reporting a saturated result when the input stops toggling.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int RESOLUTION = PWM_RESOLUTION
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_pwm,
   pwm_capture_if.master cap
);
   localparam int CW = RESOLUTION + 1;
   localparam logic [CW-1:0] FULL = {1'b1, {RESOLUTION{1'b0}}};

   typedef enum logic [1:0] {
      WAIT_EDGE,
      MEASURE,
      STEADY
   } state_t;

   state_t state, state_nx;

   logic pwm_s, pwm_q, rise;
   logic [CW-1:0] per_cnt, hi_cnt;

   logic [RESOLUTION-1:0] top_q, top_nx;
   logic [CW-1:0]         cmp_q, cmp_nx;
   logic                  valid_q, valid_nx;
   logic                  steady_q, steady_nx;

   sync_2ff u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_pwm),
      .o_q   (pwm_s)
   );

   assign rise = pwm_s & ~pwm_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pwm_q <= 1'b0;
      end else begin
         pwm_q <= pwm_s;
      end
   end

   // counters include the rise cycle itself and stop at full scale
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (rise) begin
         per_cnt <= CW'(1);
         hi_cnt  <= CW'(1);
      end else begin
         if (per_cnt != FULL)
            per_cnt <= per_cnt + 1'b1;
         if (pwm_s && hi_cnt != FULL)
            hi_cnt <= hi_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx  = state;
      top_nx    = top_q;
      cmp_nx    = cmp_q;
      valid_nx  = 1'b0;
      steady_nx = steady_q;
      unique case (state)
         WAIT_EDGE: begin
            if (rise)
               state_nx = MEASURE;
         end
         MEASURE: begin
            if (rise) begin
               top_nx   = RESOLUTION'(per_cnt - 1'b1);
               cmp_nx   = hi_cnt;
               valid_nx = 1'b1;
            end else if (per_cnt == FULL) begin
               state_nx  = STEADY;
               top_nx    = '1;
               cmp_nx    = pwm_s ? FULL : '0;
               valid_nx  = 1'b1;
               steady_nx = 1'b1;
            end
         end
         STEADY: begin
            if (rise) begin
               state_nx  = MEASURE;
               steady_nx = 1'b0;
            end
         end
         default: state_nx = WAIT_EDGE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= WAIT_EDGE;
         top_q    <= '0;
         cmp_q    <= '0;
         valid_q  <= 1'b0;
         steady_q <= 1'b0;
      end else begin
         state    <= state_nx;
         top_q    <= top_nx;
         cmp_q    <= cmp_nx;
         valid_q  <= valid_nx;
         steady_q <= steady_nx;
      end
   end

   assign cap.o_top     = top_q;
   assign cap.o_compare = cmp_q;
   assign cap.o_valid   = valid_q;
   assign cap.o_steady  = steady_q;
endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter RESOLUTION, default 8: counter resolution in bits; matches the PWM generator it measures.
REQ-002 Port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 Port i_pwm  input  1  PWM waveform, asynchronous to i_clk.
REQ-005 Port o_top  output  RESOLUTION  measured period minus 1, in i_clk cycles.
REQ-006 Port o_compare  output  RESOLUTION+1  measured high time, in i_clk cycles.
REQ-007 Port o_valid  output  1  one-cycle strobe: o_top/o_compare updated this cycle.
REQ-008 Port o_steady  output  1  high while the input is static (no rising edge within the timeout).

Function
REQ-009 i_pwm SHALL pass through a 2-flop synchronizer; a rising edge is detected when the synchronized sample is 1 and the previous sample was 0.
- Total latency: 3 cycles from i_pwm to rise detect.
REQ-010 Period counter (RESOLUTION+1 bits) and high counter (RESOLUTION+1 bits) SHALL load 1 on a rising edge, or on the first sample after entering MEASURE.
- Otherwise each cycle: period counter +1; high counter +1 when the synchronized input is 1.
REQ-011 The state machine SHALL have three states: WAIT_EDGE (after reset), MEASURE, STEADY.
REQ-012 WAIT_EDGE -> MEASURE on a rising edge; no output update.
REQ-013 MEASURE, on a rising edge, SHALL register o_top = period_cnt - 1 (truncated to RESOLUTION bits) and o_compare = high_cnt, pulse o_valid for 1 cycle, and restart the counters.
REQ-014 o_valid SHALL assert the cycle after the rise detect; o_top/o_compare SHALL be stable from that cycle until the next update.
REQ-015 MEASURE -> STEADY when period_cnt == 2^RESOLUTION and no rising edge occurs that cycle (timeout).
REQ-016 On timeout, the block SHALL pulse o_valid with o_top = 2^RESOLUTION - 1 and o_compare = 2^RESOLUTION if the synchronized input is 1, or 0 if it is 0, and set o_steady.
REQ-017 STEADY -> MEASURE on a rising edge; o_steady clears that cycle; no o_valid for that edge.
REQ-018 A rising edge coinciding with the timeout cycle SHALL take priority: normal measurement (REQ-013) applies, with period 2^RESOLUTION.
REQ-019 Counters SHALL saturate at 2^RESOLUTION and never wrap.
REQ-020 The first period after WAIT_EDGE or STEADY SHALL be measured in full; partial periods are never reported.

Reset
REQ-021 While i_rst is high: state = WAIT_EDGE, synchronizer flops = 0, counters = 0, o_top = 0, o_compare = 0, o_valid = 0, o_steady = 0.
REQ-022 Reset asserted mid-measurement SHALL discard the partial period; no o_valid for it after release.

Structure
REQ-023 A shared pwm package SHALL hold the default RESOLUTION, so the generator and pwm_capture agree.
- State encodings stay local to pwm_capture.
REQ-024 The synchronizer SHALL be a sub-module, sync_2ff, with async active-high reset clearing both flops to 0.

Verification (RESOLUTION=8, PWM generator on the same i_clk drives i_pwm)
REQ-025 Generator top=9, compare=3 -> after the first full period, o_valid every 10 cycles with o_top=9, o_compare=3.
REQ-026 Generator top=255, compare=256 (steady high) -> exactly one o_valid with o_top=255, o_compare=256; o_steady=1 thereafter, no further strobes.
REQ-027 Generator compare=0 (steady low) -> one o_valid with o_compare=0, o_top=255, o_steady=1; then compare=128 -> o_steady clears on the first edge, then o_top=255, o_compare=128.
REQ-028 Generator switches top 9->4, compare 3->2 at a period boundary -> reports change from 9/3 to 4/2 with no intermediate value.
REQ-029 i_rst pulsed mid-period with top=9, compare=5 -> outputs 0 during reset; first o_valid after release is 9/5 and follows a complete period.
REQ-030 Single-cycle high pulse every 256 cycles (top=255, compare=1) -> o_top=255, o_compare=1, o_steady stays 0 (REQ-018 boundary).
